// File: rtl/life_pkg.sv
// Shared types and constants for the Life grid control path.
// Holds the loader state enum, default grid size and a clog2 helper.
package life_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int GRID_W_DEF = 16;
  localparam int GRID_H_DEF = 16;

  // Ceiling log2, never less than 1 so counters keep a real bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/seed_loader_if.sv
// Seed bit stream from the pattern source into the loader.
// Ports: s_valid/s_data from source, s_ready back from loader.
interface seed_loader_if;

  logic s_valid;
  logic s_data;
  logic s_ready;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready
  );

endinterface

// File: rtl/seed_loader_step_prescaler.sv
// Generation-step prescaler: counts 0..DIV-1 while enabled.
// Ports: en_i count, clr_i zero, tick_o high on the last count.
module step_prescaler
  import life_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int PW = clog2(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (tick_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seed_loader.sv
// Control master for the Life cell array: serial seed load, then stepping.
// Ports: clk/rst, start, seed stream (src), run/step_req, cell strobes, status.
module seed_loader
  import life_pkg::*;
#(
  parameter int GRID_W   = GRID_W_DEF,
  parameter int GRID_H   = GRID_H_DEF,
  parameter int STEP_DIV = 5000000,
  parameter int GEN_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  seed_loader_if.slave     src,
  input  logic             run,
  input  logic             step_req,
  output logic             seed_ena,
  output logic             seed_bit,
  output logic             life_step,
  output logic             loaded,
  output logic [GEN_W-1:0] gen_count
);

  localparam int N  = GRID_W * GRID_H;
  localparam int CW = clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ena_q, ena_d;
  logic             bit_q, bit_d;
  logic             step_q, step_d;
  logic             loaded_q, loaded_d;
  logic [GEN_W-1:0] gen_q, gen_d;

  logic accept;
  logic last;
  logic pre_en;
  logic tick;

  // start wins over a bit offered in the same cycle.
  assign accept = (state_q == LOAD) && src.s_valid && !start;
  assign last   = accept && (cnt_q == LAST);
  assign pre_en = (state_q == RUN) && run && !start;

  assign src.s_ready = (state_q == LOAD);

  step_prescaler #(
    .DIV (STEP_DIV)
  ) u_pre (
    .clk    (clk),
    .rst    (rst),
    .en_i   (pre_en),
    .clr_i  (last),
    .tick_o (tick)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ena_d    = 1'b0;
    bit_d    = 1'b0;
    step_d   = 1'b0;
    loaded_d = loaded_q;
    gen_d    = gen_q;
    unique case (state_q)
      IDLE: ;
      LOAD: begin
        if (accept) begin
          ena_d = 1'b1;
          bit_d = src.s_data;
          if (last) begin
            state_d  = RUN;
            loaded_d = 1'b1;
            gen_d    = '0;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RUN: begin
        // step_req only counts while paused.
        if (run ? tick : step_req) begin
          step_d = 1'b1;
          gen_d  = gen_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Restart drops loaded now, so no new step may be issued.
    if (start) begin
      state_d  = LOAD;
      cnt_d    = '0;
      loaded_d = 1'b0;
      ena_d    = 1'b0;
      bit_d    = 1'b0;
      step_d   = 1'b0;
      gen_d    = gen_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ena_q    <= 1'b0;
      bit_q    <= 1'b0;
      step_q   <= 1'b0;
      loaded_q <= 1'b0;
      gen_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ena_q    <= ena_d;
      bit_q    <= bit_d;
      step_q   <= step_d;
      loaded_q <= loaded_d;
      gen_q    <= gen_d;
    end
  end

  assign seed_ena  = ena_q;
  assign seed_bit  = bit_q;
  assign life_step = step_q;
  assign loaded    = loaded_q;
  assign gen_count = gen_q;

endmodule

// File: tb/tb_seed_loader.sv
// Self-checking bench for seed_loader on a 4x4 grid, STEP_DIV=4.
// Ports: drives start/stream/run/step_req, models outputs and the cell grid.
module tb_seed_loader;

  localparam int W   = 4;
  localparam int H   = 4;
  localparam int N   = W * H;
  localparam int DIV = 4;
  localparam int GW  = 16;

  localparam int MI = 0;
  localparam int ML = 1;
  localparam int MR = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic run = 1'b0;
  logic step_req = 1'b0;
  logic seed_ena;
  logic seed_bit;
  logic life_step;
  logic loaded;
  logic [GW-1:0] gen_count;

  seed_loader_if sif();

  seed_loader #(
    .GRID_W   (W),
    .GRID_H   (H),
    .STEP_DIV (DIV),
    .GEN_W    (GW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .src       (sif),
    .run       (run),
    .step_req  (step_req),
    .seed_ena  (seed_ena),
    .seed_bit  (seed_bit),
    .life_step (life_step),
    .loaded    (loaded),
    .gen_count (gen_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Life on a dead-bordered W x H board, index = row*W + col.
  function automatic logic [N-1:0] life(input logic [N-1:0] g);
    logic [N-1:0] r;
    int n;
    r = '0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        n = 0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            if ((dy != 0 || dx != 0) && y + dy >= 0 && y + dy < H &&
                x + dx >= 0 && x + dx < W)
              n += int'(g[(y + dy) * W + x + dx]);
          end
        end
        r[y * W + x] = (n == 3) || (n == 2 && g[y * W + x]);
      end
    end
    return r;
  endfunction

  // Behavioural model: mode, bits taken, run-enabled cycles since load.
  int m_mode = MI;
  int m_taken = 0;
  int m_runc = 0;
  logic e_ena = 1'b0;
  logic e_bit = 1'b0;
  logic e_step = 1'b0;
  logic e_loaded = 1'b0;
  logic [GW-1:0] e_gen = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode <= MI;
      m_taken <= 0;
      m_runc <= 0;
      e_ena <= 1'b0;
      e_bit <= 1'b0;
      e_step <= 1'b0;
      e_loaded <= 1'b0;
      e_gen <= '0;
    end else begin
      e_ena <= 1'b0;
      e_bit <= 1'b0;
      e_step <= 1'b0;
      if (start) begin
        m_mode <= ML;
        m_taken <= 0;
        e_loaded <= 1'b0;
      end else if (m_mode == ML && sif.s_valid) begin
        e_ena <= 1'b1;
        e_bit <= sif.s_data;
        if (m_taken == N - 1) begin
          m_mode <= MR;
          m_taken <= 0;
          m_runc <= 0;
          e_loaded <= 1'b1;
          e_gen <= '0;
        end else begin
          m_taken <= m_taken + 1;
        end
      end else if (m_mode == MR) begin
        if (run) begin
          m_runc <= m_runc + 1;
          if (m_runc % DIV == DIV - 1) begin
            e_step <= 1'b1;
            e_gen <= e_gen + 1'b1;
          end
        end else if (step_req) begin
          e_step <= 1'b1;
          e_gen <= e_gen + 1'b1;
        end
      end
    end
  end

  // Cell-array model driven by the DUT strobes, plus pulse counters.
  logic [N-1:0] grid = '0;
  int ena_cnt = 0;
  int one_cnt = 0;
  int step_cnt = 0;

  always @(negedge clk) begin
    if (!rst && cmp_on) begin
      chk("s_ready", 32'(sif.s_ready), 32'(m_mode == ML));
      chk("seed_ena", 32'(seed_ena), 32'(e_ena));
      chk("seed_bit", 32'(seed_bit), 32'(e_bit));
      chk("life_step", 32'(life_step), 32'(e_step));
      chk("loaded", 32'(loaded), 32'(e_loaded));
      chk("gen_count", 32'(gen_count), 32'(e_gen));
      chk("ena_step_excl", 32'(seed_ena & life_step), 32'd0);
      chk("step_unloaded", 32'(life_step & ~loaded), 32'd0);
      if (seed_ena === 1'b1) begin
        grid <= {grid[N-2:0], seed_bit};
        ena_cnt <= ena_cnt + 1;
        if (seed_bit === 1'b1) one_cnt <= one_cnt + 1;
      end
      if (life_step === 1'b1) begin
        grid <= life(grid);
        step_cnt <= step_cnt + 1;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic load_bits(input logic [N-1:0] bits, input int gap,
                           input int count);
    for (int k = 0; k < count; k++) begin
      sif.s_valid = 1'b1;
      sif.s_data = bits[k];
      cyc();
      if (gap > 0) begin
        sif.s_valid = 1'b0;
        sif.s_data = 1'b0;
        repeat (gap) cyc();
      end
    end
    sif.s_valid = 1'b0;
    sif.s_data = 1'b0;
  endtask

  int e0;
  int s0;
  logic [N-1:0] pin;

  initial begin
    sif.s_valid = 1'b0;
    sif.s_data = 1'b0;

    pin = 16'h0070;
    chk("model_blinker_h2v", 32'(life(pin)), 32'h0222);
    pin = 16'h0222;
    chk("model_blinker_v2h", 32'(life(pin)), 32'h0070);

    // Reset and idle.
    #7;
    chk("rst_ena", 32'(seed_ena), 32'd0);
    chk("rst_ready", 32'(sif.s_ready), 32'd0);
    chk("rst_loaded", 32'(loaded), 32'd0);
    chk("rst_gen", 32'(gen_count), 32'd0);
    #5;
    rst = 1'b0;
    cmp_on = 1'b1;
    cyc();
    sif.s_valid = 1'b1;
    repeat (5) cyc();
    sif.s_valid = 1'b0;
    chk("idle_no_ena", 32'(ena_cnt), 32'd0);
    chk("idle_ready", 32'(sif.s_ready), 32'd0);

    // Full load, single live bit first.
    pulse_start();
    load_bits(16'h0001, 0, N);
    cyc();
    chk("full_loaded", 32'(loaded), 32'd1);
    chk("full_ena_cnt", 32'(ena_cnt), 32'd16);
    chk("full_ones", 32'(one_cnt), 32'd1);
    chk("full_grid", 32'(grid), 32'h8000);
    chk("full_gen", 32'(gen_count), 32'd0);

    // Gapped load of a horizontal blinker.
    e0 = ena_cnt;
    pulse_start();
    load_bits(16'h0E00, 2, N);
    cyc();
    chk("gap_ena_cnt", 32'(ena_cnt - e0), 32'd16);
    chk("gap_grid", 32'(grid), 32'h0070);
    chk("gap_loaded", 32'(loaded), 32'd1);

    // Free run: 22 enabled cycles leave prescaler at 2.
    e0 = ena_cnt;
    s0 = step_cnt;
    run = 1'b1;
    repeat (22) cyc();
    run = 1'b0;
    cyc();
    chk("run_steps", 32'(step_cnt - s0), 32'd5);
    chk("run_gen", 32'(gen_count), 32'd5);
    chk("run_no_ena", 32'(ena_cnt - e0), 32'd0);
    chk("run_grid", 32'(grid), 32'h0222);

    // Paused single steps; step_req while running is ignored.
    s0 = step_cnt;
    repeat (3) begin
      step_req = 1'b1;
      cyc();
      step_req = 1'b0;
      repeat (2) cyc();
    end
    run = 1'b1;
    step_req = 1'b1;
    cyc();
    run = 1'b0;
    step_req = 1'b0;
    repeat (2) cyc();
    chk("pause_steps", 32'(step_cnt - s0), 32'd3);
    chk("pause_gen", 32'(gen_count), 32'd8);
    run = 1'b1;
    cyc();
    run = 1'b0;
    repeat (2) cyc();
    chk("presc_held_gen", 32'(gen_count), 32'd9);
    chk("presc_held_grid", 32'(grid), 32'h0222);

    // Restart mid-load; coincident bit is dropped.
    e0 = ena_cnt;
    pulse_start();
    load_bits(16'h007F, 0, 7);
    start = 1'b1;
    sif.s_valid = 1'b1;
    sif.s_data = 1'b1;
    cyc();
    start = 1'b0;
    sif.s_valid = 1'b0;
    sif.s_data = 1'b0;
    load_bits(16'h0001, 0, 15);
    cyc();
    chk("restart_not_loaded", 32'(loaded), 32'd0);
    chk("restart_gen_hold", 32'(gen_count), 32'd9);
    sif.s_valid = 1'b1;
    sif.s_data = 1'b0;
    cyc();
    sif.s_valid = 1'b0;
    cyc();
    chk("restart_loaded", 32'(loaded), 32'd1);
    chk("restart_gen", 32'(gen_count), 32'd0);
    chk("restart_ena_cnt", 32'(ena_cnt - e0), 32'd23);
    chk("restart_grid", 32'(grid), 32'h8000);

    // Asynchronous reset in the middle of a run.
    run = 1'b1;
    repeat (6) cyc();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ready", 32'(sif.s_ready), 32'd0);
    chk("arst_ena", 32'(seed_ena), 32'd0);
    chk("arst_step", 32'(life_step), 32'd0);
    chk("arst_loaded", 32'(loaded), 32'd0);
    chk("arst_gen", 32'(gen_count), 32'd0);
    #3;
    rst = 1'b0;
    run = 1'b0;
    repeat (2) cyc();
    chk("post_rst_loaded", 32'(loaded), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seed_loader.md
Name: seed_loader

Overview:
- Control master for the Life cell array. It drives the two per-cell mode inputs: the seed-enable strobe and the generation-step strobe.
- In load mode it accepts seed bits over a valid/ready stream and shifts exactly GRID_W*GRID_H of them into the grid's serial seed chain. The chain is the column-0 left input, with row ends wired to the next row's start.
- In run mode it issues generation-step pulses, either from a prescaler or as single steps on request.
- It sits between the pattern source (switch/ROM reader) and the cell array top level.

Parameters:
- GRID_W, 16, cells per row.
- GRID_H, 16, rows.
- STEP_DIV, 5000000, clk cycles per automatic generation step (10 Hz at 50 MHz); must be >= 2.
- GEN_W, 16, width of the generation counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse: begin or restart a seed load.
- s_valid  in  1  seed bit available.
- s_data  in  1  seed bit (1 = alive).
- s_ready  out  1  loader accepts a seed bit this cycle.
- run  in  1  level: free-running evolution enabled.
- step_req  in  1  single-cycle pulse: one generation while paused.
- seed_ena  out  1  to all cells: shift chain one position.
- seed_bit  out  1  to chain head (first cell's left input).
- life_step  out  1  to all cells: compute next generation.
- loaded  out  1  a full N-bit seed is resident in the grid.
- gen_count  out  GEN_W  generations since last completed load.

Behaviour:
- N = GRID_W*GRID_H. Load counter width is clog2(N), minimum 1 bit.
- Reset values: state IDLE, s_ready=0, seed_ena=0, seed_bit=0, life_step=0, loaded=0, gen_count=0. Load counter and prescaler are 0.
- States:
  - IDLE: s_ready=0 and no strobes. start -> LOAD.
  - LOAD: s_ready=1 combinationally from state.
    - Accept occurs when s_valid=1 in LOAD. Next cycle: seed_ena=1 and seed_bit=accepted s_data, a registered one-cycle latency. Load counter increments.
    - seed_ena is high exactly one cycle per accepted bit and never otherwise.
    - On the accept with counter==N-1: next state RUN, loaded<=1, gen_count<=0, prescaler<=0, counter<=0.
    - The first accepted bit ends in chain position N-1 (last cell); the last accepted bit ends in position 0.
  - RUN: s_ready=0.
    - run=1: prescaler counts 0..STEP_DIV-1. On reaching STEP_DIV-1, life_step=1 the next cycle, prescaler<=0, and gen_count increments, wrapping mod 2^GEN_W.
    - run=0: prescaler holds its value. step_req -> life_step=1 next cycle, gen_count increments, prescaler unchanged.
    - step_req while run=1 is ignored.
- start in any state, including mid-LOAD:
  - Next state LOAD, counter<=0, loaded<=0. gen_count holds until the next load completes.
  - Any seed_ena or life_step already registered for that cycle still issues.
  - A bit presented in the same cycle as start is not accepted, because start has priority.
- seed_ena and life_step are never high in the same cycle.
- life_step is never high while loaded=0.
- Reset asserted mid-load or mid-run returns everything to reset values immediately. The grid keeps its partial contents; loaded=0 flags this.
- Partial loads have no timeout; LOAD waits indefinitely for s_valid.

Decomposition:
- Shared package life_pkg:
  - state enum {IDLE, LOAD, RUN}.
  - Default GRID_W/GRID_H constants, also used by the array top and the cell-array generator.
  - Function clog2.
- One natural sub-module: step_prescaler. It contains the STEP_DIV counter with enable/hold/clear and a tick output.
- The FSM, load counter and strobe registers stay in seed_loader.

Test Plan:
- Reset/idle (GRID 4x4, STEP_DIV=4): assert rst mid-cycle -> all outputs 0 asynchronously. Release, hold s_valid=1 with no start -> s_ready=0, seed_ena never 1.
- Full load: start, then 16 bits 1,0,0,...,0 with s_valid always 1 -> exactly 16 seed_ena pulses, each one cycle after its accept. seed_bit=1 only on the first pulse. loaded=1 the cycle after the 16th accept. A 4x4 cell model shows only cell 15 alive.
- Gapped stream: s_valid toggles 1,0,0,1,... over 16 bits -> seed_ena count equals accept count (16). No strobe on idle cycles. Final grid matches the pattern.
- Auto run: after load, run=1 for 20 cycles -> life_step pulses every 4th cycle (5 pulses), gen_count=5, seed_ena=0 throughout. A glider seed on the cell model evolves correctly.
- Pause/step: run=0, then step_req x3 spaced apart -> 3 life_step pulses, gen_count +3, prescaler value unchanged. step_req with run=1 -> no extra pulse.
- Restart: start after 7 accepted bits -> counter back to 0, loaded stays 0. Exactly 16 more accepts are needed to reach RUN. start coincident with s_valid -> that bit is not accepted.
